// File: rtl/branch_checkpoint_queue.sv
// In-order checkpoint queue for speculative branches: holds prediction and recovery PC,
// pops on correct resolve, flushes and emits a one-cycle redirect on mispredict.
module branch_checkpoint_queue #(
  parameter int unsigned addr_width_p = 16,
  parameter int unsigned depth_p      = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         enq_v_i,
  input  logic                         take_branch_i,
  input  logic                         speculative_i,
  input  logic [addr_width_p-1:0]      pc_i,
  input  logic [addr_width_p-1:0]      target_i,
  output logic                         ready_o,
  output logic [$clog2(depth_p)-1:0]   enq_id_o,
  input  logic                         resolve_v_i,
  input  logic                         resolve_taken_i,
  output logic                         redirect_v_o,
  output logic [addr_width_p-1:0]      redirect_pc_o,
  output logic [$clog2(depth_p):0]     count_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = $clog2(depth_p);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(depth_p);

  logic [PtrW-1:0]         head_q, head_d;
  logic [PtrW-1:0]         tail_q, tail_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    redirect_v_q, redirect_v_d;
  logic [addr_width_p-1:0] redirect_pc_q, redirect_pc_d;

  logic [depth_p-1:0]      pred_taken_q, pred_taken_d;
  logic [addr_width_p-1:0] recov_pc_q [depth_p];
  logic [addr_width_p-1:0] recov_pc_d [depth_p];

  logic ready;
  logic enq_fire;
  logic res_fire;
  logic mispredict;
  logic pop;

  // Outputs derive only from registered state; no path from the *_v_i inputs.
  assign ready      = (count_q != FullCnt) & ~redirect_v_q;
  assign enq_fire   = enq_v_i & speculative_i & ready;
  assign res_fire   = resolve_v_i & (count_q != '0);
  assign mispredict = res_fire & (resolve_taken_i != pred_taken_q[head_q]);
  assign pop        = res_fire & ~mispredict;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    redirect_v_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    pred_taken_d  = pred_taken_q;
    recov_pc_d    = recov_pc_q;

    if (mispredict) begin
      // Flush wins over any same-cycle enqueue; all younger entries are wrong-path.
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      redirect_v_d  = 1'b1;
      redirect_pc_d = recov_pc_q[head_q];
    end else begin
      if (enq_fire) begin
        pred_taken_d[tail_q] = take_branch_i;
        recov_pc_d[tail_q]   = take_branch_i ? (pc_i + addr_width_p'(1)) : target_i;
        tail_d               = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + CntW'(enq_fire) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      redirect_v_q  <= redirect_v_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Entry storage needs no reset: occupancy lives entirely in head/tail/count.
  always_ff @(posedge clk_i) begin
    pred_taken_q <= pred_taken_d;
    recov_pc_q   <= recov_pc_d;
  end

  assign ready_o       = ready;
  assign enq_id_o      = tail_q;
  assign redirect_v_o  = redirect_v_q;
  assign redirect_pc_o = redirect_pc_q;
  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);

endmodule
